// File: rtl/tick_shift_pkg.sv
// Shared definitions for the tick-stepped shift register and its helpers.
// Mode encoding is shared by anything that drives or decodes the step operation.
package tick_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider: one-cycle registered pulse every CLK_HZ/TICK_HZ cycles.
// Reset discards any partial count, so the first pulse lands a full period after release.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: CLK_HZ / TICK_HZ must be at least 2");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/tick_shift_reg.sv
// Shift register stepped by a slow divider tick (when enabled) or a single-step request.
// Each step applies hold / shift-left / shift-right / parallel-load, optionally rotating.
module tick_shift_reg
    import tick_shift_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin,
    input  logic [WIDTH-1:0] pload,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tick
);

    if (WIDTH < 2) begin : g_bad_width
        $error("tick_shift_reg: WIDTH must be at least 2");
    end

    logic             w_tick;
    logic             w_fire;
    shift_mode_t      w_mode;
    logic             w_in_l;
    logic             w_in_r;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // A tick and a manual step landing together still produce a single step.
    assign w_fire = (w_tick & en) | step;
    assign w_mode = shift_mode_t'(mode);
    assign w_in_l = rot ? r_q[WIDTH-1] : sin;
    assign w_in_r = rot ? r_q[0]       : sin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
        end else if (w_fire) begin
            case (w_mode)
                MODE_HOLD: begin
                    r_q    <= r_q;
                    r_sout <= r_sout;
                end
                MODE_SHL: begin
                    r_q    <= {r_q[WIDTH-2:0], w_in_l};
                    r_sout <= r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    r_q    <= {w_in_r, r_q[WIDTH-1:1]};
                    r_sout <= r_q[0];
                end
                MODE_LOAD: begin
                    r_q    <= pload;
                    r_sout <= r_sout;
                end
                default: begin
                    r_q    <= r_q;
                    r_sout <= r_sout;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign tick = w_tick;

endmodule

// File: tb/tb_tick_shift_reg.sv
// Directed bench for tick_shift_reg (DIV=10, WIDTH=8) with a cycle-level reference model.
// The model derives tick from elapsed cycles since reset and applies each step arithmetically.
module tb_tick_shift_reg;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst, en, step, rot, sin;
    logic [1:0] mode;
    logic [7:0] pload;
    logic [7:0] q;
    logic       sout, tick;

    int n_vec  = 0;
    int n_miss = 0;

    tick_shift_reg #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .WIDTH   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .step  (step),
        .mode  (mode),
        .rot   (rot),
        .sin   (sin),
        .pload (pload),
        .q     (q),
        .sout  (sout),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    // Reference model: m_cyc is the 1-based cycle index since the last reset edge.
    int         m_cyc   = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_q;
    logic       m_sout;
    logic       m_tick;

    assign m_tick = m_valid && (m_cyc > 1) && (((m_cyc - 1) % DIV) == 0);

    always @(posedge clk) begin
        if (rst) begin
            m_cyc   <= 1;
            m_q     <= 8'h00;
            m_sout  <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_cyc <= m_cyc + 1;
            if ((m_tick && en) || step) begin
                case (mode)
                    2'd1: begin
                        m_q    <= ((m_q << 1) | {7'd0, (rot ? m_q[7] : sin)}) & 8'hFF;
                        m_sout <= m_q[7];
                    end
                    2'd2: begin
                        m_q    <= (m_q >> 1) | ((rot ? {7'd0, m_q[0]} : {7'd0, sin}) << 7);
                        m_sout <= m_q[0];
                    end
                    2'd3: m_q <= pload;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_vec += 3;
            if (q !== m_q) begin
                n_miss++;
                $display("FAIL model_q cyc=%0d got %h want %h", m_cyc, q, m_q);
            end
            if (sout !== m_sout) begin
                n_miss++;
                $display("FAIL model_sout cyc=%0d got %b want %b", m_cyc, sout, m_sout);
            end
            if (tick !== m_tick) begin
                n_miss++;
                $display("FAIL model_tick cyc=%0d got %b want %b", m_cyc, tick, m_tick);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 40) begin
            clk1();
            k++;
        end
        n_vec++;
        if (tick !== 1'b1) begin
            n_miss++;
            $display("FAIL tick_timeout got %b want 1", tick);
        end
    endtask

    task automatic wait_tick_step();
        wait_tick();
        clk1();
    endtask

    task automatic do_step(input logic [1:0] m, input logic [7:0] pv, input logic s);
        mode  = m;
        pload = pv;
        sin   = s;
        step  = 1'b1;
        clk1();
        step  = 1'b0;
    endtask

    logic [7:0] rr_q [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    logic       rr_s [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b0; step = 1'b0; rot = 1'b0; sin = 1'b0;
        mode = 2'd0; pload = 8'h00;
        clk1();
        clk1();
        rst = 1'b0;

        // Tick period with en low: pulses only in cycles 11, 21, 31.
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            chk($sformatf("tick_period_c%0d", c), {7'd0, tick}, {7'd0, (c == 11 || c == 21 || c == 31)});
            clk1();
        end
        chk("period_q_idle", q, 8'h00);

        // Load then shift left on ticks.
        do_step(2'd3, 8'hA5, 1'b0);
        chk("load_A5", q, 8'hA5);
        mode = 2'd1; sin = 1'b1; rot = 1'b0; en = 1'b1;
        wait_tick_step();
        chk("shl1_q", q, 8'h4B);
        chk("shl1_sout", {7'd0, sout}, 8'h01);
        wait_tick_step();
        chk("shl2_q", q, 8'h97);
        chk("shl2_sout", {7'd0, sout}, 8'h00);

        // Rotate right eight times back to the start value.
        en = 1'b0;
        do_step(2'd3, 8'h81, 1'b0);
        chk("load_81", q, 8'h81);
        mode = 2'd2; rot = 1'b1; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_tick_step();
            chk($sformatf("rotr%0d_q", i), q, rr_q[i]);
            chk($sformatf("rotr%0d_sout", i), {7'd0, sout}, {7'd0, rr_s[i]});
        end

        // Step coinciding with an enabled tick yields one step only.
        en = 1'b0; rot = 1'b0;
        do_step(2'd3, 8'h01, 1'b0);
        mode = 2'd1; sin = 1'b0; en = 1'b1;
        wait_tick();
        step = 1'b1;
        clk1();
        step = 1'b0;
        chk("simul_q", q, 8'h02);

        // Reset mid-period with q=FF and sout=1.
        en = 1'b0;
        do_step(2'd3, 8'hFF, 1'b0);
        do_step(2'd1, 8'h00, 1'b1);
        chk("pre_rst_q", q, 8'hFF);
        chk("pre_rst_sout", {7'd0, sout}, 8'h01);
        wait_tick();
        for (int i = 0; i < 5; i++) clk1();
        rst = 1'b1;
        step = 1'b1;
        clk1();
        step = 1'b0;
        rst = 1'b0;
        chk("rst_q", q, 8'h00);
        chk("rst_sout", {7'd0, sout}, 8'h00);
        chk("rst_tick", {7'd0, tick}, 8'h00);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("rst_period_c%0d", c), {7'd0, tick}, {7'd0, (c == 11)});
            clk1();
        end

        // Hold mode across five ticks.
        do_step(2'd3, 8'hDA, 1'b0);
        do_step(2'd1, 8'h00, 1'b1);
        chk("pre_hold_q", q, 8'hB5);
        mode = 2'd0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_tick_step();
            chk($sformatf("hold%0d_q", i), q, 8'hB5);
            chk($sformatf("hold%0d_sout", i), {7'd0, sout}, 8'h01);
        end

        clk1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
